// File: rtl/mdr_mem_unit.sv
// mdr_mem_unit -- Memory Data Register with a memory handshake sequencer.
//
// The MDR word feeds the bus multiplexer's MDR input. It loads from the bus
// (mdr_in_en) or from memory on a read. On a write, it supplies the write
// data. A request/ready FSM holds the memory strobe until mem_ready is seen.
// busy stalls the control unit for that time. done pulses for one cycle when
// the access ends.
//
// Optional feature macro: MDR_TIMEOUT_EN
//   defined   -- a wait counter aborts an access after TIMEOUT cycles with
//                mem_ready low, and sets the sticky err flag.
//   undefined -- accesses wait indefinitely for mem_ready; err is tied 0.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   clr        synchronous active-high reset
//   bus_in     bus multiplexer output
//   mdr_in_en  load MDR from bus_in (IDLE only)
//   mar_addr   address from MAR
//   read_req   start memory read into MDR
//   write_req  start memory write from MDR
//   mem_rdata  memory read data
//   mem_ready  memory completes current access
//   mem_addr   registered access address
//   mem_wdata  registered write data
//   mem_rd     read strobe, held until accepted
//   mem_wr     write strobe, held until accepted
//   mdr_out    MDR contents
//   busy       transaction in progress
//   done       one-cycle pulse at transaction end
//   err        sticky timeout flag

module mdr_mem_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_in_en,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  // A zero or negative wait limit would make the abort compare meaningless.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mdr_mem_unit: TIMEOUT must be >= 1");
  end

  logic [1:0] state;

`ifdef MDR_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: all state here is updated with non-blocking assignments. Every
  // register then samples pre-edge values. This matters because mem_wdata
  // reads mdr_out in the same edge that can also reload mdr_out.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      mdr_out   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MDR_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (read_req) begin
            // A read wins over a simultaneous write, and also swallows a bus load.
            mem_addr <= mar_addr;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_RD;
`ifdef MDR_TIMEOUT_EN
            err_q    <= 1'b0;
            wait_cnt <= '0;
`endif
          end else begin
            if (mdr_in_en) begin
              mdr_out <= bus_in;
            end
            if (write_req) begin
              // Write the value the MDR will hold after this edge.
              mem_wdata <= mdr_in_en ? bus_in : mdr_out;
              mem_addr  <= mar_addr;
              mem_wr    <= 1'b1;
              busy      <= 1'b1;
              state     <= S_WR;
`ifdef MDR_TIMEOUT_EN
              err_q     <= 1'b0;
              wait_cnt  <= '0;
`endif
            end
          end
        end

        S_RD, S_WR: begin
          if (mem_ready) begin
            if (state == S_RD) begin
              mdr_out <= mem_rdata;
            end
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
`ifdef MDR_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            // Give up on a memory that never answers. The MDR keeps its old value.
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            err_q  <= 1'b1;
            state  <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdr_mem_unit.md
Name: mdr_mem_unit

Overview:
Memory Data Register plus memory handshake sequencer. It produces the MDR word driven onto the internal bus through the bus multiplexer's MDR input. The MDR loads either from the bus output (MDRin) or from memory on a read. On a write it drives its contents to memory. The block runs a small request/ready FSM with a wait-state counter, so slow memories stall the control unit via busy.

Parameters:
DATA_W, 32, width of MDR, bus and memory data
ADDR_W, 9, memory address width (taken from MAR low bits)
TIMEOUT, 15, max wait cycles with mem_ready low before abort (must be >= 1)

Ports:
clk  input  1  system clock, all state updates on posedge
clr  input  1  synchronous active-high reset
bus_in  input  DATA_W  bus multiplexer output
mdr_in_en  input  1  load MDR from bus_in
mar_addr  input  ADDR_W  address from MAR
read_req  input  1  start memory read into MDR
write_req  input  1  start memory write from MDR
mem_rdata  input  DATA_W  memory read data
mem_ready  input  1  memory completes current access
mem_addr  output  ADDR_W  registered access address
mem_wdata  output  DATA_W  registered write data
mem_rd  output  1  read strobe, held until accepted
mem_wr  output  1  write strobe, held until accepted
mdr_out  output  DATA_W  MDR contents, feeds bus multiplexer MDR input
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end
err  output  1  sticky timeout flag

Behaviour:
- Reset (clr=1 at posedge, any state, including mid-transaction):
  - state IDLE; mdr_out, mem_addr, mem_wdata, wait counter = 0
  - mem_rd, mem_wr, busy, done, err = 0
  - An in-flight access is abandoned without waiting for mem_ready.
- States: IDLE, RD, WR.
- IDLE:
  - read_req=1: mem_addr<=mar_addr, mem_rd<=1, busy<=1, err<=0, counter<=0 -> RD.
  - else write_req=1: mem_addr<=mar_addr, mem_wr<=1, busy<=1, err<=0, counter<=0 -> WR.
    - mem_wdata<=bus_in if mdr_in_en=1 that cycle (MDR also loads bus_in); otherwise mem_wdata<=mdr_out.
  - read_req and write_req both high: read wins, write dropped.
  - mdr_in_en=1 with no read_req: mdr_out<=bus_in. If read_req is also high, the bus load is ignored.
- RD / WR:
  - Each cycle, sample mem_ready.
  - mem_ready=1:
    - RD: mdr_out<=mem_rdata.
    - Both: drop strobe, busy<=0, done<=1 -> IDLE.
  - mem_ready=0: counter<=counter+1.
  - Counter == TIMEOUT-1 with mem_ready=0: abort. Drop strobe, busy<=0, done<=1, err<=1 -> IDLE; MDR unchanged.
  - read_req, write_req and mdr_in_en are ignored while busy (no queuing).
- Latency: request sampled at edge N; strobe high in cycle N+1. With mem_ready high in cycle N+1, MDR updates and done pulses at edge N+2 (done high for exactly one cycle), and a new request is accepted in that same cycle.
- mem_addr and mem_wdata are stable for the whole transaction.
- err clears only on clr or the next accepted request.
- Counter width is clog2(TIMEOUT)+1.

Optional Feature:
MDR_TIMEOUT_EN
- Defined: timeout counter and err behave as above.
- Undefined: no counter. RD/WR wait indefinitely for mem_ready; err is tied 0.

Test Plan:
- clr mid-RD after 3 wait cycles -> next cycle mem_rd=0, busy=0, mdr_out=0, state IDLE; a late mem_ready=1 has no effect.
- IDLE, mdr_in_en=1, bus_in=0xDEADBEEF -> mdr_out=0xDEADBEEF next cycle, mem_rd/mem_wr stay 0.
- read_req with mar_addr=0x05; mem_ready high 2 cycles later with mem_rdata=0x12345678 -> mem_addr=0x05, mem_rd high 3 cycles, mdr_out=0x12345678, single done pulse, err=0.
- write_req with mdr_in_en=1, bus_in=0x000000AA, mar_addr=0x1F; mem_ready immediate -> mem_wr high 1 cycle, mem_wdata=0xAA, mem_addr=0x1F, done pulses.
- read_req and write_req together -> only mem_rd asserts; write_req during busy is ignored, no second transaction.
- MDR_TIMEOUT_EN, TIMEOUT=15, mem_ready held 0 -> abort after 15 cycles: err=1, done pulse, mdr_out unchanged. Next read_req clears err.
